// File: rtl/pacote_video.sv
// Shared frame geometry, pixel format and writer FSM encoding for the frame RAM path.
package pacote_video;

   localparam int unsigned LARGURA_QUADRO   = 320;
   localparam int unsigned ALTURA_QUADRO    = 240;
   localparam int unsigned TOTAL_PIXELS     = LARGURA_QUADRO * ALTURA_QUADRO;
   localparam int unsigned ULTIMO_ENDERECO  = TOTAL_PIXELS - 1;
   localparam int unsigned BITS_PIXEL       = 8;
   localparam int unsigned BITS_COLUNA      = 9;
   localparam int unsigned BITS_LINHA       = 8;
   localparam int unsigned BITS_ENDERECO    = 17;

   typedef enum logic [1:0] {
      OCIOSO     = 2'd0,
      ESCREVENDO = 2'd1,
      FIM        = 2'd2
   } estado_t;

   // Linear address of the last pixel of a frame of the given geometry.
   function automatic int unsigned ultimo_endereco(input int unsigned largura,
                                                   input int unsigned altura);
      return largura * altura - 1;
   endfunction

endpackage

// File: rtl/contador_raster.sv
// x/y/linear-address counters of the next expected pixel in raster order.
module contador_raster
   import pacote_video::*;
#(
   parameter int unsigned LARGURA     = LARGURA_QUADRO,
   parameter int unsigned ALTURA      = ALTURA_QUADRO,
   parameter int unsigned LARGURA_END = BITS_ENDERECO
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   limpar,
   input  logic                   reiniciar,
   input  logic                   incrementar,
   output logic [BITS_COLUNA-1:0] coluna,
   output logic [BITS_LINHA-1:0]  linha,
   output logic [LARGURA_END-1:0] endereco,
   output logic                   ultimo_c
);

   localparam logic [LARGURA_END-1:0] END_ULTIMO = LARGURA_END'(ultimo_endereco(LARGURA, ALTURA));
   localparam logic [BITS_COLUNA-1:0] COL_ULTIMA = BITS_COLUNA'(LARGURA - 1);

   // Current pixel is the last one of the frame.
   assign ultimo_c = (endereco == END_ULTIMO);

   // Clear, restart after pixel 0 was taken, or advance by one pixel.
   always_ff @(posedge clock) begin
      if (!reset) begin
         coluna   <= '0;
         linha    <= '0;
         endereco <= '0;
      end else if (limpar) begin
         coluna   <= '0;
         linha    <= '0;
         endereco <= '0;
      end else if (reiniciar) begin
         coluna   <= BITS_COLUNA'(1);
         linha    <= '0;
         endereco <= LARGURA_END'(1);
      end else if (incrementar) begin
         endereco <= endereco + LARGURA_END'(1);
         if (coluna == COL_ULTIMA) begin
            coluna <= '0;
            linha  <= linha + BITS_LINHA'(1);
         end else begin
            coluna <= coluna + BITS_COLUNA'(1);
         end
      end
   end

endmodule

// File: rtl/escritor_quadro_ram.sv
// Frame RAM writer: takes a valid/ready pixel stream and writes it in raster order to port B.
module escritor_quadro_ram
   import pacote_video::*;
#(
   parameter int unsigned LARGURA     = LARGURA_QUADRO,
   parameter int unsigned ALTURA      = ALTURA_QUADRO,
   parameter int unsigned LARGURA_END = BITS_ENDERECO
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   habilitar,
   input  logic [BITS_PIXEL-1:0]  pixel_entrada,
   input  logic                   pixel_valido,
   input  logic                   inicio_quadro,
   output logic                   pixel_pronto,
   output logic [LARGURA_END-1:0] endereco_ram,
   output logic [BITS_PIXEL-1:0]  dados_ram,
   output logic                   escrita_ram,
   output logic [BITS_COLUNA-1:0] coluna_atual,
   output logic [BITS_LINHA-1:0]  linha_atual,
   output logic                   escrevendo,
   output logic                   quadro_completo,
   output logic                   erro_sincronia
);

   estado_t                estado;
   estado_t                estado_prox;
   logic                   transferencia_c;
   logic                   escreve_c;
   logic                   erro_c;
   logic                   reiniciar_c;
   logic                   incrementar_c;
   logic                   limpar_c;
   logic                   pronto_prox_c;
   logic                   ultimo_c;
   logic [LARGURA_END-1:0] endereco_cont;
   logic [LARGURA_END-1:0] endereco_esc_c;

   assign transferencia_c = pixel_valido && pixel_pronto;

   contador_raster #(
      .LARGURA     (LARGURA),
      .ALTURA      (ALTURA),
      .LARGURA_END (LARGURA_END)
   ) u_contador (
      .clock       (clock),
      .reset       (reset),
      .limpar      (limpar_c),
      .reiniciar   (reiniciar_c),
      .incrementar (incrementar_c),
      .coluna      (coluna_atual),
      .linha       (linha_atual),
      .endereco    (endereco_cont),
      .ultimo_c    (ultimo_c)
   );

   // State register.
   always_ff @(posedge clock) begin
      if (!reset) estado <= OCIOSO;
      else        estado <= estado_prox;
   end

   // Next state, write request and counter control.
   always_comb begin
      estado_prox    = estado;
      escreve_c      = 1'b0;
      erro_c         = 1'b0;
      reiniciar_c    = 1'b0;
      incrementar_c  = 1'b0;
      limpar_c       = 1'b0;
      endereco_esc_c = endereco_cont;
      pronto_prox_c  = 1'b0;

      case (estado)
         OCIOSO: begin
            if (transferencia_c) begin
               if (inicio_quadro) begin
                  escreve_c      = 1'b1;
                  endereco_esc_c = '0;
                  reiniciar_c    = 1'b1;
                  estado_prox    = ESCREVENDO;
               end else begin
                  erro_c = 1'b1;
               end
            end
         end
         ESCREVENDO: begin
            if (transferencia_c) begin
               escreve_c = 1'b1;
               if (inicio_quadro) begin
                  // Early start-of-frame: resynchronise on this pixel.
                  endereco_esc_c = '0;
                  reiniciar_c    = 1'b1;
                  erro_c         = 1'b1;
               end else if (ultimo_c) begin
                  // Clear instead of incrementing so the address never leaves the frame.
                  limpar_c    = 1'b1;
                  estado_prox = FIM;
               end else begin
                  incrementar_c = 1'b1;
               end
            end
         end
         FIM: begin
            limpar_c    = 1'b1;
            estado_prox = OCIOSO;
         end
         default: begin
            limpar_c    = 1'b1;
            estado_prox = OCIOSO;
         end
      endcase

      case (estado_prox)
         OCIOSO:     pronto_prox_c = habilitar;
         ESCREVENDO: pronto_prox_c = 1'b1;
         default:    pronto_prox_c = 1'b0;
      endcase
   end

   // Registered handshake, RAM write port and status pulses.
   always_ff @(posedge clock) begin
      if (!reset) begin
         pixel_pronto    <= 1'b0;
         escrita_ram     <= 1'b0;
         endereco_ram    <= '0;
         dados_ram       <= '0;
         escrevendo      <= 1'b0;
         quadro_completo <= 1'b0;
         erro_sincronia  <= 1'b0;
      end else begin
         pixel_pronto    <= pronto_prox_c;
         escrita_ram     <= escreve_c;
         if (escreve_c) begin
            endereco_ram <= endereco_esc_c;
            dados_ram    <= pixel_entrada;
         end
         escrevendo      <= (estado_prox == ESCREVENDO);
         quadro_completo <= (estado_prox == FIM);
         erro_sincronia  <= erro_c;
      end
   end

endmodule
